// File: rtl/pll_drp_reconfig.sv
// Dynamic-reconfiguration master for a 7-series PLL DRP port.
// On a start request it holds the PLL in reset, then read-modify-writes
// every entry of the selected register table. After that it releases the
// PLL reset and pulses SRDY once LOCKED returns. Every output is registered.
module pll_drp_reconfig #(
   parameter int                     NUM_REGS     = 3,
   parameter logic [NUM_REGS*39-1:0] S1_TABLE     = '0,
   parameter logic [NUM_REGS*39-1:0] S2_TABLE     = '0,
   parameter int                     DRDY_TIMEOUT = 64,
   parameter int                     LOCK_TIMEOUT = 4096
) (
   input  logic        DCLK,
   input  logic        RST,
   input  logic        SEN,
   input  logic        SADDR,
   output logic        SRDY,
   output logic        BUSY,
   output logic        ERROR,
   output logic        RST_PLL,
   output logic [6:0]  DADDR,
   output logic        DEN,
   output logic        DWE,
   output logic [15:0] DI,
   input  logic [15:0] DO,
   input  logic        DRDY,
   input  logic        LOCKED
);

   localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int TMR_MAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REGS - 1);
   localparam logic [TMR_W-1:0] DRDY_LIMIT = TMR_W'(DRDY_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] LOCK_LIMIT = TMR_W'(LOCK_TIMEOUT - 1);

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_ASSERT_RST = 4'd1,
      ST_READ       = 4'd2,
      ST_WAIT_R     = 4'd3,
      ST_MODIFY     = 4'd4,
      ST_WRITE      = 4'd5,
      ST_WAIT_W     = 4'd6,
      ST_WAIT_LOCK  = 4'd7,
      ST_DONE       = 4'd8
   } state_t;

   // Registered state and outputs
   state_t            state_r;
   logic [IDX_W-1:0]  index_r;
   logic [TMR_W-1:0]  timer_r;
   logic              table_sel_r;
   logic [15:0]       rdata_r;
   logic              srdy_r;
   logic              busy_r;
   logic              error_r;
   logic              rst_pll_r;
   logic              den_r;
   logic              dwe_r;
   logic [6:0]        daddr_r;
   logic [15:0]       di_r;

   // Next-state values
   state_t            state_s;
   logic [IDX_W-1:0]  index_s;
   logic [TMR_W-1:0]  timer_s;
   logic              table_sel_s;
   logic [15:0]       rdata_s;
   logic              srdy_s;
   logic              busy_s;
   logic              error_s;
   logic              rst_pll_s;
   logic              den_s;
   logic              dwe_s;
   logic [6:0]        daddr_s;
   logic [15:0]       di_s;

   // Table lookup: current entry and the one a WAIT_W -> READ step moves to
   logic [38:0]       s1_mem [NUM_REGS];
   logic [38:0]       s2_mem [NUM_REGS];
   logic [38:0]       cur_entry_s;
   logic [38:0]       nxt_entry_s;
   logic [IDX_W-1:0]  index_inc_s;

   genvar g;
   generate
      for (g = 0; g < NUM_REGS; g++) begin : g_tbl
         assign s1_mem[g] = S1_TABLE[39*g +: 39];
         assign s2_mem[g] = S2_TABLE[39*g +: 39];
      end
   endgenerate

   // Saturate the look-ahead index so it never addresses past the table
   assign index_inc_s = (index_r == LAST_IDX) ? index_r : index_r + IDX_W'(1);
   assign cur_entry_s = table_sel_r ? s2_mem[index_r]     : s1_mem[index_r];
   assign nxt_entry_s = table_sel_r ? s2_mem[index_inc_s] : s1_mem[index_inc_s];

   assign SRDY    = srdy_r;
   assign BUSY    = busy_r;
   assign ERROR   = error_r;
   assign RST_PLL = rst_pll_r;
   assign DADDR   = daddr_r;
   assign DEN     = den_r;
   assign DWE     = dwe_r;
   assign DI      = di_r;

   // Next-state and next-output decode; pulses default low, the rest hold
   always_comb begin
      state_s     = state_r;
      index_s     = index_r;
      timer_s     = timer_r;
      table_sel_s = table_sel_r;
      rdata_s     = rdata_r;
      srdy_s      = 1'b0;
      busy_s      = busy_r;
      error_s     = error_r;
      rst_pll_s   = rst_pll_r;
      den_s       = 1'b0;
      dwe_s       = 1'b0;
      daddr_s     = daddr_r;
      di_s        = di_r;

      case (state_r)
         ST_IDLE: begin
            if (SEN) begin
               table_sel_s = SADDR;
               error_s     = 1'b0;
               busy_s      = 1'b1;
               rst_pll_s   = 1'b1;
               index_s     = '0;
               state_s     = ST_ASSERT_RST;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ASSERT_RST: begin
            den_s   = 1'b1;
            daddr_s = cur_entry_s[38:32];
            timer_s = '0;
            state_s = ST_READ;
         end
         ST_READ: begin
            // DRDY coinciding with the DEN cycle is deliberately not looked at
            state_s = ST_WAIT_R;
         end
         ST_WAIT_R: begin
            if (DRDY) begin
               rdata_s = DO;
               state_s = ST_MODIFY;
            end else if (timer_r == DRDY_LIMIT) begin
               // PLL stays in reset: its registers may be half written
               error_s = 1'b1;
               busy_s  = 1'b0;
               state_s = ST_IDLE;
            end else begin
               timer_s = timer_r + TMR_W'(1);
            end
         end
         ST_MODIFY: begin
            // Mask bits set keep the PLL's current value
            di_s    = (rdata_r & cur_entry_s[31:16]) | (cur_entry_s[15:0] & ~cur_entry_s[31:16]);
            den_s   = 1'b1;
            dwe_s   = 1'b1;
            daddr_s = cur_entry_s[38:32];
            state_s = ST_WRITE;
         end
         ST_WRITE: begin
            timer_s = '0;
            state_s = ST_WAIT_W;
         end
         ST_WAIT_W: begin
            if (DRDY) begin
               timer_s = '0;
               if (index_r == LAST_IDX) begin
                  rst_pll_s = 1'b0;
                  state_s   = ST_WAIT_LOCK;
               end else begin
                  index_s = index_inc_s;
                  den_s   = 1'b1;
                  daddr_s = nxt_entry_s[38:32];
                  state_s = ST_READ;
               end
            end else if (timer_r == DRDY_LIMIT) begin
               error_s = 1'b1;
               busy_s  = 1'b0;
               state_s = ST_IDLE;
            end else begin
               timer_s = timer_r + TMR_W'(1);
            end
         end
         ST_WAIT_LOCK: begin
            if (LOCKED) begin
               srdy_s  = 1'b1;
               state_s = ST_DONE;
            end else if (timer_r == LOCK_LIMIT) begin
               error_s = 1'b1;
               busy_s  = 1'b0;
               state_s = ST_IDLE;
            end else begin
               timer_s = timer_r + TMR_W'(1);
            end
         end
         ST_DONE: begin
            busy_s  = 1'b0;
            state_s = ST_IDLE;
         end
         default: begin
            busy_s    = 1'b0;
            rst_pll_s = 1'b0;
            state_s   = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous controller reset
   always_ff @(posedge DCLK) begin
      if (RST) begin
         state_r     <= ST_IDLE;
         index_r     <= '0;
         timer_r     <= '0;
         table_sel_r <= 1'b0;
         rdata_r     <= 16'h0000;
         srdy_r      <= 1'b0;
         busy_r      <= 1'b0;
         error_r     <= 1'b0;
         rst_pll_r   <= 1'b0;
         den_r       <= 1'b0;
         dwe_r       <= 1'b0;
         daddr_r     <= 7'h00;
         di_r        <= 16'h0000;
      end else begin
         state_r     <= state_s;
         index_r     <= index_s;
         timer_r     <= timer_s;
         table_sel_r <= table_sel_s;
         rdata_r     <= rdata_s;
         srdy_r      <= srdy_s;
         busy_r      <= busy_s;
         error_r     <= error_s;
         rst_pll_r   <= rst_pll_s;
         den_r       <= den_s;
         dwe_r       <= dwe_s;
         daddr_r     <= daddr_s;
         di_r        <= di_s;
      end
   end

endmodule

// File: tb/tb_pll_drp_reconfig.sv
// Directed bench for pll_drp_reconfig: DRP slave and PLL lock models,
// scoreboard of expected DRP accesses, latency and timeout checks.
module tb_pll_drp_reconfig;

   localparam int NREG = 3;
   localparam logic [116:0] S1_T = {7'h0A, 16'h0000, 16'h1234,
                                    7'h09, 16'hFF00, 16'h00AA,
                                    7'h08, 16'h1000, 16'h0145};
   localparam logic [116:0] S2_T = {7'h16, 16'hFFFF, 16'h0000,
                                    7'h15, 16'hF0F0, 16'h0505,
                                    7'h14, 16'h00FF, 16'hAB00};

   logic        DCLK = 1'b0;
   logic        RST;
   logic        SEN;
   logic        SADDR;
   logic        SRDY, BUSY, ERROR, RST_PLL, DEN, DWE;
   logic [6:0]  DADDR;
   logic [15:0] DI;
   logic [15:0] DO;
   logic        DRDY;
   logic        LOCKED;

   int          tests = 0;
   int          fails = 0;
   int          srdy_cnt = 0;
   int          drdy_delay = 1;
   int          lock_delay = 1;
   bit          drdy_en = 1'b1;
   bit          lock_en = 1'b1;
   logic [15:0] do_val = 16'hFFFF;
   logic [23:0] exp_q[$];   // {is_write, addr[6:0], di[15:0]}

   pll_drp_reconfig #(
      .NUM_REGS     (NREG),
      .S1_TABLE     (S1_T),
      .S2_TABLE     (S2_T),
      .DRDY_TIMEOUT (16),
      .LOCK_TIMEOUT (32)
   ) dut (
      .DCLK    (DCLK),
      .RST     (RST),
      .SEN     (SEN),
      .SADDR   (SADDR),
      .SRDY    (SRDY),
      .BUSY    (BUSY),
      .ERROR   (ERROR),
      .RST_PLL (RST_PLL),
      .DADDR   (DADDR),
      .DEN     (DEN),
      .DWE     (DWE),
      .DI      (DI),
      .DO      (DO),
      .DRDY    (DRDY),
      .LOCKED  (LOCKED)
   );

   always #5 DCLK = ~DCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [38:0] tbl_entry(input logic sel, input int i);
      logic [116:0] t;
      t = sel ? S2_T : S1_T;
      return t[39*i +: 39];
   endfunction

   task automatic push_read(input logic sel, input int i);
      logic [38:0] e;
      e = tbl_entry(sel, i);
      exp_q.push_back({1'b0, e[38:32], 16'h0000});
   endtask

   task automatic push_run(input logic sel, input logic [15:0] dov);
      logic [38:0] e;
      for (int i = 0; i < NREG; i++) begin
         e = tbl_entry(sel, i);
         exp_q.push_back({1'b0, e[38:32], 16'h0000});
         exp_q.push_back({1'b1, e[38:32], (dov & e[31:16]) | (e[15:0] & ~e[31:16])});
      end
   endtask

   // DRP slave: answers each DEN after drdy_delay cycles with do_val
   initial begin
      DRDY = 1'b0;
      DO   = 16'hDEAD;
      forever begin
         @(negedge DCLK);
         if (DEN && drdy_en) begin
            repeat (drdy_delay) @(posedge DCLK);
            #1;
            DRDY = 1'b1;
            DO   = do_val;
            @(posedge DCLK);
            #1;
            DRDY = 1'b0;
            DO   = 16'hDEAD;
         end
      end
   end

   // PLL lock model: unlocked while in reset, relocks lock_delay cycles after release
   initial begin
      logic prev;
      LOCKED = 1'b0;
      prev   = 1'b0;
      forever begin
         @(negedge DCLK);
         if (RST_PLL) LOCKED = 1'b0;
         else if (prev && lock_en) begin
            repeat (lock_delay) @(posedge DCLK);
            #1;
            LOCKED = 1'b1;
         end
         prev = RST_PLL;
      end
   end

   // Scoreboard: every DEN pops one expected access
   always @(negedge DCLK) begin
      logic [23:0] it;
      if (SRDY) srdy_cnt++;
      if (DWE) check("dwe_with_den", DEN, 1);
      if (DEN) begin
         check("rst_pll_during_access", RST_PLL, 1);
         if (exp_q.size() == 0) check("unexpected_den", DEN, 0);
         else begin
            it = exp_q.pop_front();
            check("drp_dwe", DWE, it[23]);
            check("drp_addr", DADDR, it[22:16]);
            if (it[23]) check("drp_di", DI, it[15:0]);
         end
      end
   end

   // Pulse SEN; returns with the bench in cycle 1 (first cycle after the SEN edge)
   task automatic start(input logic sel);
      @(posedge DCLK); #1;
      SEN = 1'b1; SADDR = sel;
      @(posedge DCLK); #1;
      SEN = 1'b0;
   endtask

   task automatic run_normal(input logic sel, input logic [15:0] dov, input int k,
                             input int lk, input bit resend);
      int cnt;
      int base;
      drdy_delay = k; lock_delay = lk; do_val = dov; drdy_en = 1'b1; lock_en = 1'b1;
      push_run(sel, dov);
      base = srdy_cnt;
      start(sel);
      cnt = 1;
      check("error_cleared", ERROR, 0);
      check("busy_cycle1", BUSY, 1);
      check("rst_pll_cycle1", RST_PLL, 1);
      while (!SRDY && cnt < 1000) begin
         @(posedge DCLK); #1;
         if (resend && cnt == 10) begin
            SEN = 1'b1; SADDR = ~sel;
         end else begin
            SEN = 1'b0;
         end
         cnt++;
      end
      SEN = 1'b0;
      check("srdy_latency", cnt, 2 + NREG * (2 * k + 3) + lk + 1);
      @(posedge DCLK); #1;
      check("srdy_one_cycle", SRDY, 0);
      check("busy_after_done", BUSY, 0);
      check("rst_pll_released", RST_PLL, 0);
      check("no_error", ERROR, 0);
      check("single_srdy", srdy_cnt - base, 1);
      check("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int base;
      RST = 1'b1; SEN = 1'b0; SADDR = 1'b0;
      repeat (2) @(posedge DCLK);
      #1;
      check("rst_srdy", SRDY, 0);
      check("rst_busy", BUSY, 0);
      check("rst_error", ERROR, 0);
      check("rst_rst_pll", RST_PLL, 0);
      check("rst_den", DEN, 0);
      check("rst_dwe", DWE, 0);
      check("rst_daddr", DADDR, 0);
      check("rst_di", DI, 0);
      RST = 1'b0;

      // S1 table, DO all ones, DRDY one cycle after DEN
      run_normal(1'b0, 16'hFFFF, 1, 2, 1'b0);
      // S2 table, slow DRP, SEN re-pulsed with SADDR flipped while busy
      run_normal(1'b1, 16'h5A5A, 5, 3, 1'b1);

      // DRDY never returns: timeout leaves PLL in reset
      drdy_en = 1'b0;
      push_read(1'b0, 0);
      start(1'b0);
      @(posedge DCLK); #1;
      check("to_den_cycle2", DEN, 1);
      repeat (16) @(posedge DCLK);
      #1;
      check("to_error_before", ERROR, 0);
      check("to_busy_before", BUSY, 1);
      @(posedge DCLK); #1;
      check("to_error", ERROR, 1);
      check("to_busy", BUSY, 0);
      check("to_rst_pll_held", RST_PLL, 1);
      exp_q.delete();
      repeat (4) @(posedge DCLK);
      #1;
      check("to_error_sticky", ERROR, 1);
      check("to_rst_pll_sticky", RST_PLL, 1);
      run_normal(1'b0, 16'h0000, 2, 1, 1'b0);

      // LOCKED never returns
      lock_en = 1'b0; drdy_delay = 2; do_val = 16'h1111;
      push_run(1'b1, 16'h1111);
      base = srdy_cnt;
      start(1'b1);
      cnt = 1;
      while (RST_PLL && cnt < 300) begin
         @(posedge DCLK); #1;
         cnt++;
      end
      check("lock_wait_entry", cnt, 2 + NREG * (2 * 2 + 3));
      repeat (31) @(posedge DCLK);
      #1;
      check("lk_error_before", ERROR, 0);
      check("lk_busy_before", BUSY, 1);
      @(posedge DCLK); #1;
      check("lk_error", ERROR, 1);
      check("lk_busy", BUSY, 0);
      check("lk_rst_pll", RST_PLL, 0);
      check("lk_no_srdy", srdy_cnt - base, 0);
      check("lk_queue_drained", exp_q.size(), 0);
      lock_en = 1'b1;

      // Controller reset while waiting for the first write's DRDY
      drdy_delay = 5; lock_delay = 2; do_val = 16'h00F0;
      push_run(1'b0, 16'h00F0);
      base = srdy_cnt;
      start(1'b0);
      repeat (9) @(posedge DCLK);
      #1;
      check("ww_busy", BUSY, 1);
      check("ww_two_accesses", exp_q.size(), 2 * NREG - 2);
      RST = 1'b1;
      @(posedge DCLK); #1;
      RST = 1'b0;
      exp_q.delete();
      check("ar_srdy", SRDY, 0);
      check("ar_busy", BUSY, 0);
      check("ar_error", ERROR, 0);
      check("ar_rst_pll", RST_PLL, 0);
      check("ar_den", DEN, 0);
      check("ar_dwe", DWE, 0);
      check("ar_daddr", DADDR, 0);
      check("ar_di", DI, 0);
      repeat (10) @(posedge DCLK);
      #1;
      check("late_drdy_busy", BUSY, 0);
      check("late_drdy_rst_pll", RST_PLL, 0);
      check("late_drdy_error", ERROR, 0);
      check("late_drdy_no_srdy", srdy_cnt - base, 0);
      run_normal(1'b1, 16'hC3C3, 1, 1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
